// File: rtl/uart_pkg.sv
// Shared types and constants for the wb_uart receive/transmit cores.
package uart_pkg;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_t;

   localparam int FRAME_DATA_BITS = 8;
   localparam int SAMPLE_NUM_MIN  = 4;

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: pulses tick once every max(div,1) clocks.
module uart_baud_tick #(
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             restart,
   input  logic [DIV_W-1:0] div,
   output logic             tick
);

   logic [DIV_W-1:0] cnt;
   logic [DIV_W-1:0] last;

   // A divider of 0 behaves like 1, so the last count is 0 in both cases.
   assign last = (div == '0) ? '0 : div - DIV_W'(1);
   assign tick = (cnt == last);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (restart || tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + DIV_W'(1);
      end
   end

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: 8N1 deserializer with oversampled 3-sample majority vote
// and a valid/ready output register reporting framing error and overrun.
module uart_rx_core
   import uart_pkg::*;
#(
   parameter int SAMPLE_NUM = 16,
   parameter int DIV_W      = 16
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic [DIV_W-1:0] baud_div_i,
   input  logic             rx_i,
   output logic [7:0]       data_o,
   output logic             frame_err_o,
   output logic             valid_o,
   input  logic             ready_i,
   output logic             overrun_o,
   output logic             busy_o
);

   localparam int SCNT_W = $clog2(SAMPLE_NUM);
   localparam int MID    = SAMPLE_NUM / 2;

   localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(SAMPLE_NUM - 1);
   localparam logic [SCNT_W-1:0] SCNT_S0   = SCNT_W'(MID - 1);
   localparam logic [SCNT_W-1:0] SCNT_S1   = SCNT_W'(MID);
   localparam logic [SCNT_W-1:0] SCNT_S2   = SCNT_W'(MID + 1);
   localparam logic [2:0]        BCNT_LAST = 3'(FRAME_DATA_BITS - 1);

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   logic              sync1_p0, sync2_p1, rx_d_p2;
   logic              fall;
   rx_state_t         state;
   logic [SCNT_W-1:0] scnt;
   logic [2:0]        bcnt;
   logic [DIV_W-1:0]  div_q;
   logic [1:0]        smp;
   logic [7:0]        shreg;
   logic              tick, restart, vote, at_vote, bit_end, complete;

   // Stage p0..p2: two-flop synchronizer, then a delay flop for edge detection.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         sync1_p0 <= 1'b1;
         sync2_p1 <= 1'b1;
         rx_d_p2  <= 1'b1;
      end else begin
         sync1_p0 <= rx_i;
         sync2_p1 <= sync1_p0;
         rx_d_p2  <= sync2_p1;
      end
   end

   assign fall    = rx_d_p2 & ~sync2_p1;
   assign restart = fall && (state == RX_IDLE);

   uart_baud_tick #(
      .DIV_W (DIV_W)
   ) u_tick (
      .clk     (clk_i),
      .rst_n   (rst_n_i),
      .restart (restart),
      .div     (div_q),
      .tick    (tick)
   );

   // The third sample is the live line, so the vote is ready on tick mid+1.
   assign vote     = maj3(smp[1], smp[0], sync2_p1);
   assign at_vote  = tick && (scnt == SCNT_S2);
   assign bit_end  = tick && (scnt == SCNT_LAST);
   assign complete = (state == RX_STOP) && at_vote;
   assign busy_o   = (state != RX_IDLE);

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state <= RX_IDLE;
         scnt  <= '0;
         bcnt  <= '0;
         div_q <= '0;
      end else if (state == RX_IDLE) begin
         if (fall) begin
            state <= RX_START;
            scnt  <= '0;
            bcnt  <= '0;
            div_q <= baud_div_i;
         end
      end else if (tick) begin
         scnt <= bit_end ? '0 : scnt + SCNT_W'(1);
         if (state == RX_START) begin
            if (at_vote && vote) begin
               state <= RX_IDLE;
            end else if (bit_end) begin
               state <= RX_DATA;
            end
         end else if (state == RX_DATA) begin
            if (bit_end) begin
               bcnt <= bcnt + 3'd1;
               if (bcnt == BCNT_LAST) begin
                  state <= RX_STOP;
               end
            end
         end else if (at_vote) begin
            state <= RX_IDLE;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (tick && (scnt == SCNT_S0)) begin
         smp[1] <= sync2_p1;
      end
      if (tick && (scnt == SCNT_S1)) begin
         smp[0] <= sync2_p1;
      end
      if ((state == RX_DATA) && at_vote) begin
         shreg <= {vote, shreg[7:1]};
      end
   end

   // Output register: a completion may reload in the same cycle the old byte is taken.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         data_o      <= 8'h00;
         frame_err_o <= 1'b0;
         valid_o     <= 1'b0;
         overrun_o   <= 1'b0;
      end else begin
         overrun_o <= 1'b0;
         if (complete) begin
            if (!valid_o || ready_i) begin
               data_o      <= shreg;
               frame_err_o <= !vote;
               valid_o     <= 1'b1;
            end else begin
               overrun_o <= 1'b1;
            end
         end else if (valid_o && ready_i) begin
            valid_o <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: serial frames driven at 27 clocks/tick, 16 ticks/bit.
module tb_uart_rx_core;

   localparam int DIV      = 27;
   localparam int BIT_CLKS = DIV * 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] baud_div = 16'(DIV);
   logic        rx = 1'b1;
   logic        ready = 1'b1;
   logic [7:0]  data;
   logic        frame_err, valid, overrun, busy;

   int n_run = 0;
   int n_fail = 0;
   int cyc = 0;
   int ovr_cnt = 0;
   int start_cyc = 0;
   int busy_rise = 0;
   int valid_rise = 0;
   logic busy_q = 1'b0;
   logic valid_q = 1'b0;
   logic [8:0] rxq[$];

   uart_rx_core dut (
      .clk_i       (clk),
      .rst_n_i     (rst_n),
      .baud_div_i  (baud_div),
      .rx_i        (rx),
      .data_o      (data),
      .frame_err_o (frame_err),
      .valid_o     (valid),
      .ready_i     (ready),
      .overrun_o   (overrun),
      .busy_o      (busy)
   );

   always #10 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (valid && ready) rxq.push_back({frame_err, data});
      if (overrun) ovr_cnt <= ovr_cnt + 1;
   end

   always @(negedge clk) begin
      if (busy && !busy_q) busy_rise = cyc;
      if (valid && !valid_q) valid_rise = cyc;
      busy_q = busy;
      valid_q = valid;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_run++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Called on a negedge; returns on a negedge with the line high.
   task automatic send_frame(input logic [7:0] b, input logic stop);
      rx = 1'b0;
      start_cyc = cyc;
      repeat (BIT_CLKS) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (BIT_CLKS) @(negedge clk);
      end
      rx = stop;
      repeat (BIT_CLKS) @(negedge clk);
      rx = 1'b1;
   endtask

   initial begin
      int ovr_base;
      int diff;
      logic seen_idle;

      // Reset state
      repeat (4) @(negedge clk);
      check("reset_data", 32'(data), 32'h00);
      check("reset_valid", 32'(valid), 32'h0);
      check("reset_ferr", 32'(frame_err), 32'h0);
      check("reset_overrun", 32'(overrun), 32'h0);
      check("reset_busy", 32'(busy), 32'h0);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);

      // Single byte, with edge-to-busy and byte latency
      rxq.delete();
      send_frame(8'hA5, 1'b1);
      repeat (50) @(negedge clk);
      check("single_count", 32'(rxq.size()), 32'd1);
      if (rxq.size() > 0) check("single_byte", 32'(rxq[0]), 32'h0A5);
      check("edge_to_busy", 32'(busy_rise - start_cyc), 32'd3);
      diff = valid_rise - start_cyc;
      n_run++;
      assert (diff >= 4150 && diff <= 4170) else begin
         n_fail++;
         $error("FAIL byte_latency: observed %0d expected 4150..4170", diff);
      end

      // Glitch rejection
      rxq.delete();
      rx = 1'b0;
      repeat (100) @(negedge clk);
      check("glitch_busy_high", 32'(busy), 32'h1);
      rx = 1'b1;
      seen_idle = 1'b0;
      for (int i = 0; i < 216 && !seen_idle; i++) begin
         @(negedge clk);
         if (!busy) seen_idle = 1'b1;
      end
      check("glitch_busy_drop", 32'(seen_idle), 32'h1);
      repeat (500) @(negedge clk);
      check("glitch_no_byte", 32'(rxq.size()), 32'd0);

      // Framing error then a clean frame with the same data
      rxq.delete();
      send_frame(8'h3C, 1'b0);
      repeat (300) @(negedge clk);
      send_frame(8'h3C, 1'b1);
      repeat (50) @(negedge clk);
      check("ferr_count", 32'(rxq.size()), 32'd2);
      if (rxq.size() > 1) begin
         check("ferr_bad_stop", 32'(rxq[0]), 32'h13C);
         check("ferr_good_stop", 32'(rxq[1]), 32'h03C);
      end

      // Backpressure and overrun
      rxq.delete();
      ready = 1'b0;
      ovr_base = ovr_cnt;
      send_frame(8'h11, 1'b1);
      send_frame(8'h22, 1'b1);
      repeat (100) @(negedge clk);
      check("bp_valid_held", 32'(valid), 32'h1);
      check("bp_data_held", 32'(data), 32'h11);
      check("bp_overrun_once", 32'(ovr_cnt - ovr_base), 32'd1);
      ready = 1'b1;
      @(negedge clk);
      ready = 1'b0;
      check("bp_valid_cleared", 32'(valid), 32'h0);
      check("bp_taken", 32'(rxq.size() > 0 ? rxq[0] : 9'h1FF), 32'h011);
      ready = 1'b1;
      repeat (20) @(negedge clk);

      // Back-to-back frames with no idle time
      rxq.delete();
      ovr_base = ovr_cnt;
      send_frame(8'h00, 1'b1);
      send_frame(8'hFF, 1'b1);
      send_frame(8'h55, 1'b1);
      repeat (50) @(negedge clk);
      check("b2b_count", 32'(rxq.size()), 32'd3);
      if (rxq.size() > 2) begin
         check("b2b_byte0", 32'(rxq[0]), 32'h000);
         check("b2b_byte1", 32'(rxq[1]), 32'h0FF);
         check("b2b_byte2", 32'(rxq[2]), 32'h055);
      end
      check("b2b_no_overrun", 32'(ovr_cnt - ovr_base), 32'd0);

      // Reset during data bit 4
      rxq.delete();
      rx = 1'b0;
      repeat (BIT_CLKS) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         rx = i[0];
         repeat (BIT_CLKS) @(negedge clk);
      end
      rx = 1'b0;
      repeat (200) @(negedge clk);
      rst_n = 1'b0;
      rx = 1'b1;
      #1;
      check("rst_async_busy", 32'(busy), 32'h0);
      check("rst_async_data", 32'(data), 32'h00);
      check("rst_async_valid", 32'(valid), 32'h0);
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      repeat (1000) @(negedge clk);
      check("rst_no_byte", 32'(rxq.size()), 32'd0);
      send_frame(8'h81, 1'b1);
      repeat (50) @(negedge clk);
      check("rst_next_count", 32'(rxq.size()), 32'd1);
      if (rxq.size() > 0) check("rst_next_byte", 32'(rxq[0]), 32'h081);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
